// File: rtl/pump_duty_meter.sv
// rtl/pump_duty_meter.sv - recovers the PWM duty word from the dithered pump bitstream
// Counts synchronized high samples over a fixed window and reports value, delta, edges and lock.
module pump_duty_meter #(
  parameter int WINDOW       = 60000,
  parameter int STABLE_TOL   = 2,
  parameter int STABLE_COUNT = 10
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               pump_in,
  input  logic               enable,
  output logic [15:0]        recovered_pwm,
  output logic signed [16:0] delta,
  output logic [15:0]        edge_count,
  output logic               duty_valid,
  output logic               locked
);

  localparam int              SCW         = $clog2(STABLE_COUNT + 1);
  localparam logic [15:0]     LAST_SAMPLE = 16'(WINDOW - 1);
  localparam logic [SCW-1:0]  STABLE_MAX  = SCW'(STABLE_COUNT);
  localparam logic [16:0]     TOL         = 17'(STABLE_TOL);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic               r_pump_m;
  logic               r_pump_s;
  logic               r_pump_d;
  logic [15:0]        r_sample_cnt;
  logic [15:0]        r_high_cnt;
  logic [15:0]        r_edge_cnt;
  logic [15:0]        r_prev;
  logic [SCW-1:0]     r_stable_cnt;
  logic               r_have_prev;
  logic [15:0]        r_recovered;
  logic [15:0]        r_edge_out;
  logic signed [16:0] r_delta;
  logic               r_duty_valid;
  logic               r_locked;

  logic               w_last;
  logic               w_rise;
  logic               w_stable_win;
  logic signed [16:0] w_diff;
  logic signed [16:0] w_delta;
  logic [16:0]        w_abs;
  logic [SCW-1:0]     w_stable_next;

  // pump_in is asynchronous: two flops for metastability, a third for edge detection
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pump_m <= 1'b0;
      r_pump_s <= 1'b0;
      r_pump_d <= 1'b0;
    end else begin
      r_pump_m <= pump_in;
      r_pump_s <= r_pump_m;
      r_pump_d <= r_pump_s;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  assign w_last = (r_sample_cnt == LAST_SAMPLE);
  assign w_rise = r_pump_s & ~r_pump_d;

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_MEASURE;
        S_MEASURE: if (w_last) w_next = S_PUBLISH;
        S_PUBLISH: w_next = S_MEASURE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // The first window after IDLE has no reference, so its delta is forced to zero
  assign w_diff       = $signed({1'b0, r_high_cnt}) - $signed({1'b0, r_prev});
  assign w_delta      = r_have_prev ? w_diff : 17'sd0;
  assign w_abs        = w_delta[16] ? $unsigned(-w_delta) : $unsigned(w_delta);
  assign w_stable_win = r_have_prev && (w_abs <= TOL);

  always_comb begin
    w_stable_next = '0;
    if (w_stable_win) begin
      w_stable_next = (r_stable_cnt == STABLE_MAX) ? r_stable_cnt : r_stable_cnt + SCW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sample_cnt <= '0;
      r_high_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_prev       <= '0;
      r_stable_cnt <= '0;
      r_have_prev  <= 1'b0;
      r_recovered  <= '0;
      r_edge_out   <= '0;
      r_delta      <= '0;
      r_duty_valid <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_duty_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sample_cnt <= '0;
          r_high_cnt   <= '0;
          r_edge_cnt   <= '0;
          r_stable_cnt <= '0;
          r_have_prev  <= 1'b0;
          r_locked     <= 1'b0;
        end
        S_MEASURE: begin
          r_sample_cnt <= r_sample_cnt + 16'd1;
          if (r_pump_s) r_high_cnt <= r_high_cnt + 16'd1;
          if (w_rise && (r_edge_cnt != 16'hFFFF)) r_edge_cnt <= r_edge_cnt + 16'd1;
          if (!enable) r_locked <= 1'b0;
        end
        S_PUBLISH: begin
          r_recovered  <= r_high_cnt;
          r_edge_out   <= r_edge_cnt;
          r_delta      <= w_delta;
          r_prev       <= r_high_cnt;
          r_have_prev  <= 1'b1;
          r_stable_cnt <= w_stable_next;
          r_locked     <= (w_stable_next == STABLE_MAX);
          r_duty_valid <= 1'b1;
          r_sample_cnt <= '0;
          r_high_cnt   <= '0;
          r_edge_cnt   <= '0;
        end
        default: begin
          r_sample_cnt <= '0;
          r_high_cnt   <= '0;
          r_edge_cnt   <= '0;
        end
      endcase
    end
  end

  assign recovered_pwm = r_recovered;
  assign delta         = r_delta;
  assign edge_count    = r_edge_out;
  assign duty_valid    = r_duty_valid;
  assign locked        = r_locked;

endmodule

// File: tb/tb_pump_duty_meter.sv
// tb/tb_pump_duty_meter.sv - scoreboard bench for pump_duty_meter
// A window-level model predicts each strobe from the recorded pump history.
module tb_pump_duty_meter;

  localparam int W   = 300;
  localparam int TOL = 2;
  localparam int SC  = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pump_in = 1'b0;
  logic               enable = 1'b0;
  logic [15:0]        recovered_pwm;
  logic signed [16:0] delta;
  logic [15:0]        edge_count;
  logic               duty_valid;
  logic               locked;

  pump_duty_meter #(.WINDOW(W), .STABLE_TOL(TOL), .STABLE_COUNT(SC)) dut (
    .clk_in(clk), .rst_in(rst), .pump_in(pump_in), .enable(enable),
    .recovered_pwm(recovered_pwm), .delta(delta), .edge_count(edge_count),
    .duty_valid(duty_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int hi;
    int dl;
    int ed;
    bit lk;
  } exp_t;

  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  bit   pin [0:65535];
  int   pat_p = 1;
  int   pat_h = 0;
  bit   rnd = 1'b0;
  bit   force_low = 1'b1;
  int   ph = 0;
  exp_t q[$];
  exp_t last_e;
  int   n_strobes = 0;
  int   last_strobe_cyc = 0;

  bit   run_active = 1'b0;
  int   run_start = 0;
  bit   have_prev = 1'b0;
  int   prev = 0;
  int   stable_run = 0;

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Pump driver: periodic pattern (P samples, first H high) or random bits
  initial forever begin
    @(negedge clk);
    if (force_low)  pump_in = 1'b0;
    else if (rnd)   pump_in = 1'($urandom_range(0, 1));
    else            pump_in = ((ph % pat_p) < pat_h);
    ph++;
    if (cyc + 1 < 65536) pin[cyc + 1] = pump_in;
  end

  // Window model: a run starts at the first enabled edge; every W+1 edges later a window
  // of the W preceding edges is published. Each edge sees pump as driven two edges earlier.
  function automatic void publish(int k);
    exp_t e;
    int hi = 0;
    int ed = 0;
    for (int j = k - W; j < k; j++) begin
      if (pin[j - 2]) hi++;
      if (pin[j - 2] && !pin[j - 3]) ed++;
    end
    e.cyc = k;
    e.hi  = hi;
    e.ed  = ed;
    e.dl  = have_prev ? hi - prev : 0;
    if (have_prev && e.dl <= TOL && e.dl >= -TOL) stable_run++;
    else stable_run = 0;
    e.lk = (stable_run >= SC);
    prev = hi;
    have_prev = 1'b1;
    q.push_back(e);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rst) begin
      run_active = 1'b0;
    end else if (!run_active) begin
      if (enable) begin
        run_active = 1'b1;
        run_start  = cyc;
        have_prev  = 1'b0;
        stable_run = 0;
      end
    end else begin
      if ((cyc - run_start) % (W + 1) == 0) publish(cyc);
      if (!enable) run_active = 1'b0;
    end
  end

  // Monitor: compare every strobe against the oldest prediction
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (duty_valid) begin
        n_strobes++;
        last_strobe_cyc = cyc;
        if (q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e = q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("recovered_pwm", int'(recovered_pwm), e.hi);
          chk("delta", int'(delta), e.dl);
          chk("edge_count", int'(edge_count), e.ed);
          chk("locked", int'(locked), int'(e.lk));
          last_e = e;
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missed_strobe", 0, 1);
      end
    end
  end

  task automatic wait_strobes(input int n);
    int tgt;
    int budget;
    tgt = n_strobes + n;
    budget = n * (W + 1) + 2 * W + 10;
    while (n_strobes < tgt && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (n_strobes < tgt) chk("strobe_timeout", n_strobes, tgt);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_recovered"}, int'(recovered_pwm), 0);
    chk({tag, "_delta"}, int'(delta), 0);
    chk({tag, "_edges"}, int'(edge_count), 0);
    chk({tag, "_valid"}, int'(duty_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
  endtask

  initial begin
    int divs[8] = '{2, 3, 4, 5, 10, 12, 25, 60};
    int ns_before;
    int first_edge;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    pat_p = 1; pat_h = 1;
    repeat (3) @(negedge clk);
    force_low = 1'b0;

    // constant high
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_strobes(2);

    // 1/3 duty dither from a fresh enable
    @(negedge clk);
    enable = 1'b0;
    pat_p = 3; pat_h = 1;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    wait_strobes(10);
    chk("dither_not_locked_10th", int'(locked), 0);
    wait_strobes(1);
    chk("dither_locked_11th", int'(locked), 1);
    wait_strobes(1);

    // step 100 -> 150, then 150 -> 100 -> 102
    pat_p = 6; pat_h = 3;
    wait_strobes(1);
    chk("step_unlocks", int'(locked), 0);
    wait_strobes(11);
    chk("step_relocks", int'(locked), 1);
    pat_p = 150; pat_h = 50;
    wait_strobes(12);
    chk("lock_at_100", int'(locked), 1);
    pat_h = 51;
    wait_strobes(3);
    chk("small_step_keeps_lock", int'(locked), 1);

    // enable drop mid-window
    repeat (150) @(negedge clk);
    enable = 1'b0;
    ns_before = n_strobes;
    repeat (400) @(negedge clk);
    chk("no_strobe_while_off", n_strobes, ns_before);
    chk("off_locked", int'(locked), 0);
    chk("off_hold_recovered", int'(recovered_pwm), last_e.hi);
    chk("off_hold_delta", int'(delta), last_e.dl);
    chk("off_hold_edges", int'(edge_count), last_e.ed);
    enable = 1'b1;
    wait_strobes(1);
    chk("reenable_delta_zero", int'(delta), 0);

    // asynchronous reset mid-measure
    repeat (100) @(negedge clk);
    force_low = 1'b1;
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    first_edge = cyc + 1;
    wait_strobes(1);
    chk("restart_latency", last_strobe_cyc - first_edge, W + 1);
    force_low = 1'b0;
    wait_strobes(1);

    // constant low
    pat_p = 1; pat_h = 0;
    wait_strobes(13);
    chk("low_locked", int'(locked), 1);
    chk("low_recovered", int'(recovered_pwm), 0);
    chk("low_edges", int'(edge_count), 0);

    // randomized bits and patterns
    rnd = 1'b1;
    wait_strobes(3);
    rnd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pat_p = divs[$urandom_range(0, 7)];
      pat_h = $urandom_range(0, pat_p);
      wait_strobes(3);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pump_duty_meter.md
# pump_duty_meter

Recovers the VCXO tuning word from the dithered `pump` bitstream by counting high samples over a fixed window, which reconstructs the PWM duty value. It sits on the monitor side of the VCXO loop: its `pump_in` is wired to the pump output driving the VCXO loop filter. It reports each recovered value with a strobe, the window-to-window change, the dither edge activity and a stability/lock flag for telemetry.

## Interface
- `WINDOW`, 60000 — samples per measurement; equals the PWM full-scale period, so a constant-high pump reads `WINDOW`. Range 2..65535.
- `STABLE_TOL`, 2 — maximum |delta| in counts for a window to count as stable.
- `STABLE_COUNT`, 10 — number of consecutive stable windows required to assert `locked`.

- `clk_in`  in  1 — sample clock, same frequency as the PWM generator clock.
- `rst_in`  in  1 — asynchronous, active-high reset.
- `pump_in`  in  1 — pump bitstream; treated as asynchronous to `clk_in`.
- `enable`  in  1 — measurement enable; level-sensitive.
- `recovered_pwm`  out  16 — high-sample count of the last completed window.
- `delta`  out  17 signed — `recovered_pwm` minus the previous window's value.
- `edge_count`  out  16 — rising edges of pump seen in the last window.
- `duty_valid`  out  1 — one-cycle strobe when the three outputs above update.
- `locked`  out  1 — recovered value has been stable for `STABLE_COUNT` windows.

## Operation
- **Synchronizer:** `pump_in` passes through a 2-flop synchronizer to give `pump_s`. A third flop, `pump_d`, is used for edge detection. All three flops reset to 0.
- **States:**
  - IDLE (reset state).
  - MEASURE.
  - PUBLISH.
- **IDLE**
  - Sample counter, high counter, edge counter, stable counter and the first-window flag are all cleared.
  - `locked` is held at 0.
  - `enable`=1 moves to MEASURE on the next edge.
- **MEASURE**
  - Each cycle, the sample counter increments.
  - The high counter increments when `pump_s`=1.
  - The edge counter increments on `pump_s`=1 with `pump_d`=0, saturating at 65535.
  - When the sample counter equals `WINDOW`-1, that sample is counted and the state moves to PUBLISH.
- **PUBLISH** (one cycle)
  - `recovered_pwm` takes the high count; `edge_count` takes the edge count.
  - `delta` takes high count − previous value, computed in 17-bit signed. On the first window after entering MEASURE from IDLE, `delta` is 0.
  - The previous value is updated to the high count.
  - `duty_valid` is 1 for exactly this cycle's registered output, i.e. high in the cycle after the PUBLISH edge.
  - Counters clear and the state returns to MEASURE. The pump sample in the PUBLISH cycle is discarded.
- **Stability**
  - In PUBLISH, if the window is not the first and |new delta| ≤ `STABLE_TOL`, the stable counter increments, saturating at `STABLE_COUNT`. Otherwise it clears to 0.
  - `locked` = (stable counter == `STABLE_COUNT`), registered, and updates together with `duty_valid`.
  - An unstable window drops `locked` in the same update.
- **`enable` deasserted in any state:** go to IDLE on the next edge.
  - The partial window is discarded and no `duty_valid` is issued.
  - `locked` goes to 0.
  - `recovered_pwm`, `delta` and `edge_count` hold their last values.
- **`rst_in` mid-operation:** all state and outputs immediately take their reset values.
- **Arithmetic:** the high counter cannot exceed `WINDOW`, so it needs no saturation. `delta` range is ±`WINDOW`, which fits in 17 bits signed.

## Timing
- **Reset values:**
  - `recovered_pwm`=0, `delta`=0, `edge_count`=0.
  - `duty_valid`=0, `locked`=0.
  - State IDLE.
- **Input latency:** a change on `pump_in` affects the counters 2 cycles later, because of the synchronizer.
- **Measurement period:**
  - Steady-state period is `WINDOW`+1 clocks, giving one `duty_valid` per period.
  - First `duty_valid` after `enable` rises (enable sampled 1 at edge N): N+1 enters MEASURE, N+`WINDOW` enters PUBLISH, `duty_valid` is high in cycle N+`WINDOW`+1.
- **Output timing:** `duty_valid` is never high for two consecutive cycles. Outputs are stable between strobes.
- **`enable` drop in the PUBLISH cycle:** the PUBLISH edge update still occurs and `duty_valid` still fires. The following edge goes to IDLE.

## Test plan
- **Constant high** (`WINDOW`=300): `pump_in`=1, enable → `recovered_pwm`=300, `edge_count`≤1, first `delta`=0, `duty_valid` high at cycle N+301.
- **1/3 duty dither** (`WINDOW`=300): repeating 1,0,0 pattern → `recovered_pwm`=100 every window, `edge_count`=100, `delta`=0 after the first window, `locked`=1 on the 11th `duty_valid` (first window excluded, then 10 stable).
- **Step in duty:** change pattern from 100 to 150 high samples per window → `delta`=+50 on the step window and `locked` drops to 0 there. `locked` reasserts 10 windows later. A step of +2 keeps `locked`.
- **Enable drop mid-window** (sample 150 of 300): no `duty_valid`, `locked`=0, outputs hold. Re-enable → first strobe has `delta`=0.
- **Async reset mid-MEASURE:** all outputs return to 0 without waiting for a clock. After release with enable=1, the first strobe arrives exactly `WINDOW`+1 cycles after the first enabled edge.
- **Constant low:** `recovered_pwm`=0, `edge_count`=0. Combined with a stable previous value of 0, `locked` asserts after the stable sequence.
